// File: rtl/rcv_pkg.sv
// Shared types and helpers for the serial receiver: FSM state encoding and parity.
package rcv_pkg;
    localparam int MAX_DATA_BITS = 16;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

    // Expected parity bit for a data word; callers zero-extend narrower words.
    function automatic logic parity_calc(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction
endpackage

// File: rtl/rcv_fifo.sv
// Synchronous FIFO with simultaneous push/pop; storage resets to all ones so the head reads 1s when empty.
module rcv_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_push,
    input  logic                    i_pop,
    input  logic [DATA_WIDTH-1:0]   i_data,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;
    logic                  w_do_pop;
    logic                  w_do_push;

    assign o_full   = (r_count == (AW+1)'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_data   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '1;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/rcv_block_fifo.sv
// UART-style receiver: centre-sampled start/data/parity/stop bits feeding a receive FIFO with error flags.
module rcv_block_fifo
    import rcv_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 10,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_serial_in,
    input  logic                          i_data_read,
    output logic [DATA_BITS-1:0]          o_rx_data,
    output logic                          o_data_ready,
    output logic                          o_overrun_error,
    output logic                          o_framing_error,
    output logic                          o_parity_error,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int TW   = $clog2(CLKS_PER_BIT);
    localparam int CW   = $clog2(DATA_BITS);

    rx_state_t             r_state;
    logic [1:0]            r_sync;
    logic                  r_rx_prev;
    logic [TW-1:0]         r_timer;
    logic [CW-1:0]         r_bit_cnt;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_par_bit;
    logic                  r_framing_error;
    logic                  r_parity_error;
    logic                  r_overrun_error;
    logic                  r_push;
    logic [DATA_BITS-1:0]  r_push_data;

    logic w_rx, w_fell, w_tick_half, w_tick_bit, w_par_bad;
    logic w_full, w_empty, w_pop;

    assign w_rx        = r_sync[1];
    assign w_fell      = r_rx_prev & ~w_rx;
    // The synchroniser and edge detect cost ~1.5 clocks, so the start re-check fires that much early.
    assign w_tick_half = (r_timer == TW'(HALF - 2));
    assign w_tick_bit  = (r_timer == TW'(CLKS_PER_BIT - 1));
    assign w_par_bad   = (PARITY_EN != 0) &&
                         (r_par_bit != parity_calc(MAX_DATA_BITS'(r_shift), PARITY_ODD != 0));
    assign w_pop       = i_data_read & ~w_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync          <= 2'b11;
            r_rx_prev       <= 1'b1;
            r_state         <= IDLE;
            r_timer         <= '0;
            r_bit_cnt       <= '0;
            r_shift         <= '0;
            r_par_bit       <= 1'b0;
            r_framing_error <= 1'b0;
            r_parity_error  <= 1'b0;
            r_push          <= 1'b0;
            r_push_data     <= '0;
        end else begin
            r_sync    <= {r_sync[0], i_serial_in};
            r_rx_prev <= w_rx;
            r_push    <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_timer <= '0;
                    if (w_fell) begin
                        r_state         <= START;
                        r_framing_error <= 1'b0;
                        r_parity_error  <= 1'b0;
                    end
                end
                START: begin
                    if (w_tick_half) begin
                        r_timer   <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= w_rx ? IDLE : DATA;
                    end else r_timer <= r_timer + TW'(1);
                end
                DATA: begin
                    if (w_tick_bit) begin
                        r_timer <= '0;
                        r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
                        if (r_bit_cnt == CW'(DATA_BITS - 1))
                            r_state <= (PARITY_EN != 0) ? PARITY : STOP;
                        else
                            r_bit_cnt <= r_bit_cnt + CW'(1);
                    end else r_timer <= r_timer + TW'(1);
                end
                PARITY: begin
                    if (w_tick_bit) begin
                        r_timer   <= '0;
                        r_par_bit <= w_rx;
                        r_state   <= STOP;
                    end else r_timer <= r_timer + TW'(1);
                end
                STOP: begin
                    if (w_tick_bit) begin
                        r_timer         <= '0;
                        r_state         <= IDLE;
                        r_framing_error <= ~w_rx;
                        r_parity_error  <= w_par_bad;
                        r_push          <= w_rx & ~w_par_bad;
                        r_push_data     <= r_shift;
                    end else r_timer <= r_timer + TW'(1);
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Overrun is sticky until the host pops; a drop only happens when no pop frees a slot.
    always_ff @(posedge i_clk) begin
        if (i_rst)                          r_overrun_error <= 1'b0;
        else if (r_push && w_full && !w_pop) r_overrun_error <= 1'b1;
        else if (w_pop)                     r_overrun_error <= 1'b0;
    end

    rcv_fifo #(
        .DATA_WIDTH (DATA_BITS),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (r_push),
        .i_pop   (w_pop),
        .i_data  (r_push_data),
        .o_data  (o_rx_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (o_fifo_count)
    );

    assign o_data_ready    = ~w_empty;
    assign o_overrun_error = r_overrun_error;
    assign o_framing_error = r_framing_error;
    assign o_parity_error  = r_parity_error;
endmodule

// File: tb/tb_rcv_block_fifo.sv
// Bench for rcv_block_fifo: directed and random frames against a queue-based frame model.
`timescale 1ns/1ps
module tb_rcv_block_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sa = 1'b1, sp = 1'b1;
    logic       rd_a = 1'b0, rd_p = 1'b0;
    logic [7:0] rx_a, rx_p;
    logic       rdy_a, rdy_p, ovr_a, ovr_p, fe_a, fe_p, pe_a, pe_p;
    logic [2:0] cnt_a, cnt_p;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] q_a[$];
    logic [7:0] q_p[$];
    logic       m_ovr_a = 0, m_fe_a = 0;
    logic       m_ovr_p = 0, m_fe_p = 0, m_pe_p = 0;

    always #5 clk = ~clk;

    rcv_block_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(10), .PARITY_EN(0), .PARITY_ODD(0), .FIFO_DEPTH(4)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_serial_in(sa), .i_data_read(rd_a),
        .o_rx_data(rx_a), .o_data_ready(rdy_a), .o_overrun_error(ovr_a),
        .o_framing_error(fe_a), .o_parity_error(pe_a), .o_fifo_count(cnt_a));

    rcv_block_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(10), .PARITY_EN(1), .PARITY_ODD(0), .FIFO_DEPTH(4)) u_dut_p (
        .i_clk(clk), .i_rst(rst), .i_serial_in(sp), .i_data_read(rd_p),
        .o_rx_data(rx_p), .o_data_ready(rdy_p), .o_overrun_error(ovr_p),
        .o_framing_error(fe_p), .o_parity_error(pe_p), .o_fifo_count(cnt_p));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit p, input logic v);
        if (p) sp = v; else sa = v;
    endtask

    // Serial frame: start, 8 data LSB first, optional parity, stop, then 3 idle bit times.
    task automatic tx_frame(input bit p, input logic [7:0] d, input logic par, input logic stop,
                            input realtime bit_ns);
        @(negedge clk);
        drive(p, 1'b0); #(bit_ns);
        for (int i = 0; i < 8; i++) begin drive(p, d[i]); #(bit_ns); end
        if (p) begin drive(p, par); #(bit_ns); end
        drive(p, stop); #(bit_ns);
        drive(p, 1'b1); #(3.0 * bit_ns);
    endtask

    task automatic model_a(input logic [7:0] d, input logic stop);
        m_fe_a = ~stop;
        if (stop) begin
            if (q_a.size() == 4) m_ovr_a = 1'b1;
            else q_a.push_back(d);
        end
    endtask

    task automatic model_p(input logic [7:0] d, input logic par, input logic stop);
        m_fe_p = ~stop;
        m_pe_p = (par != ^d);
        if (stop && !m_pe_p) begin
            if (q_p.size() == 4) m_ovr_p = 1'b1;
            else q_p.push_back(d);
        end
    endtask

    task automatic send_a(input logic [7:0] d, input logic stop, input realtime bit_ns);
        tx_frame(1'b0, d, 1'b0, stop, bit_ns);
        model_a(d, stop);
    endtask

    task automatic send_p(input logic [7:0] d, input logic par, input logic stop);
        tx_frame(1'b1, d, par, stop, 100.0);
        model_p(d, par, stop);
    endtask

    task automatic pop_a;
        @(negedge clk); rd_a = 1'b1;
        @(negedge clk); rd_a = 1'b0;
        if (q_a.size() != 0) begin void'(q_a.pop_front()); m_ovr_a = 1'b0; end
    endtask

    task automatic pop_p;
        @(negedge clk); rd_p = 1'b1;
        @(negedge clk); rd_p = 1'b0;
        if (q_p.size() != 0) begin void'(q_p.pop_front()); m_ovr_p = 1'b0; end
    endtask

    task automatic check_a(input string tag);
        @(negedge clk);
        chk({tag, ".a.ready"}, rdy_a, q_a.size() != 0);
        chk({tag, ".a.count"}, cnt_a, q_a.size());
        if (q_a.size() != 0) chk({tag, ".a.data"}, rx_a, q_a[0]);
        chk({tag, ".a.ovr"}, ovr_a, m_ovr_a);
        chk({tag, ".a.fe"}, fe_a, m_fe_a);
        chk({tag, ".a.pe"}, pe_a, 1'b0);
    endtask

    task automatic check_p(input string tag);
        @(negedge clk);
        chk({tag, ".p.ready"}, rdy_p, q_p.size() != 0);
        chk({tag, ".p.count"}, cnt_p, q_p.size());
        if (q_p.size() != 0) chk({tag, ".p.data"}, rx_p, q_p[0]);
        chk({tag, ".p.ovr"}, ovr_p, m_ovr_p);
        chk({tag, ".p.fe"}, fe_p, m_fe_p);
        chk({tag, ".p.pe"}, pe_p, m_pe_p);
    endtask

    initial begin
        realtime rates[3];
        logic [7:0] d;
        logic       s, pb;
        rates[0] = 96.0; rates[1] = 100.0; rates[2] = 104.0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        chk("rst.rx_data", rx_a, 8'hFF);
        check_a("rst");
        check_p("rst");

        // Nominal frame then a single read
        send_a(8'hD5, 1'b1, 100.0);
        check_a("d5");
        pop_a();
        check_a("d5.read");

        // Bit-rate skew in both directions
        send_a(8'hD5, 1'b1, 96.0);
        check_a("slow96");
        send_a(8'hA3, 1'b1, 104.0);
        check_a("fast104");
        pop_a(); check_a("skew.pop1");
        pop_a(); check_a("skew.pop2");

        // Framing error then recovery
        send_a(8'h3C, 1'b0, 100.0);
        check_a("frame_err");
        send_a(8'h11, 1'b1, 100.0);
        check_a("frame_recover");
        pop_a(); check_a("frame_recover.pop");

        // Even parity: wrong bit rejected, right bit accepted
        send_p(8'h01, 1'b0, 1'b1);
        check_p("par_bad");
        send_p(8'h01, 1'b1, 1'b1);
        check_p("par_good");
        pop_p(); check_p("par.pop");

        // Overrun: five frames into a four-deep FIFO
        for (int i = 1; i <= 5; i++) send_a(8'(i), 1'b1, 100.0);
        check_a("ovr.full");
        for (int i = 0; i < 4; i++) begin
            chk("ovr.head", rx_a, 8'(i + 1));
            pop_a(); check_a("ovr.pop");
        end

        // One-clock glitch must not start a frame
        @(negedge clk); sa = 1'b0;
        @(negedge clk); sa = 1'b1;
        repeat (30) @(negedge clk);
        check_a("glitch");

        // Reset in the middle of a frame with data queued
        send_a(8'h5A, 1'b1, 100.0);
        check_a("pre_rst");
        @(negedge clk); sa = 1'b0; #(100.0);
        sa = 1'b1; #(100.0); sa = 1'b0; #(150.0);
        @(negedge clk); rst = 1'b1; sa = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q_a.delete(); q_p.delete();
        m_ovr_a = 0; m_fe_a = 0; m_ovr_p = 0; m_fe_p = 0; m_pe_p = 0;
        check_a("mid_rst");
        send_a(8'h96, 1'b1, 100.0);
        check_a("post_rst");

        // Random frames on both receivers with random reads
        for (int n = 0; n < 30; n++) begin
            d = 8'($urandom);
            s = ($urandom_range(0, 4) != 0);
            send_a(d, s, rates[$urandom_range(0, 2)]);
            check_a("rnd_a");
            for (int k = $urandom_range(0, 2); k > 0; k--) begin pop_a(); check_a("rnd_a.pop"); end
        end
        for (int n = 0; n < 20; n++) begin
            d  = 8'($urandom);
            pb = ($urandom_range(0, 3) == 0) ? ~(^d) : ^d;
            s  = ($urandom_range(0, 5) != 0);
            send_p(d, pb, s);
            check_p("rnd_p");
            for (int k = $urandom_range(0, 2); k > 0; k--) begin pop_p(); check_p("rnd_p.pop"); end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
